// File: rtl/sel_mux_8bit.sv
// One-hot-select read-back mux: fixed priority a > b > c > d, zero when idle, plus a registered copy and a sticky collision flag.
// Latency: o and sel_any are combinational (0 cycles); o_q and collision update one clk edge after their inputs.
// Backpressure: none; the block has no handshake, so every input change is reflected and never held off.
module sel_mux_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_addr,
    input  logic [WIDTH-1:0] a,
    input  logic             b_addr,
    input  logic [WIDTH-1:0] b,
    input  logic             c_addr,
    input  logic [WIDTH-1:0] c,
    input  logic             d_addr,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_err,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic             sel_any,
    output logic             collision
);

    logic multi_sel;

    // Only the winning source's data is ever read, so X on an unselected source stays off o.
    always_comb begin
        o = '0;
        if (a_addr)      o = a;
        else if (b_addr) o = b;
        else if (c_addr) o = c;
        else if (d_addr) o = d;
    end

    assign sel_any   = a_addr | b_addr | c_addr | d_addr;
    assign multi_sel = (a_addr & b_addr) | (a_addr & c_addr) | (a_addr & d_addr) |
                       (b_addr & c_addr) | (b_addr & d_addr) | (c_addr & d_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= '0;
            collision <= 1'b0;
        end else begin
            o_q <= o;
            // A fresh collision outranks a clear on the same edge.
            if (multi_sel)    collision <= 1'b1;
            else if (clr_err) collision <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sel_mux_8bit.sv
// Directed-vector bench for sel_mux_8bit; stimulus queues hand-computed expectations, a monitor process checks them.
module tb_sel_mux_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_addr, b_addr, c_addr, d_addr, clr_err;
    logic [7:0] a, b, c, d;
    logic [7:0] o, o_q;
    logic       sel_any, collision;

    typedef struct {
        string      name;
        logic [7:0] o;
        logic       sel_any;
        logic [7:0] o_q;
        logic       collision;
    } exp_t;

    exp_t exp_q[$];
    event push_ev;
    int   done_cnt = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    sel_mux_8bit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr(a_addr), .a(a), .b_addr(b_addr), .b(b),
        .c_addr(c_addr), .c(c), .d_addr(d_addr), .d(d),
        .clr_err(clr_err),
        .o(o), .o_q(o_q), .sel_any(sel_any), .collision(collision)
    );

    always #5 clk = ~clk;

    // Monitor: samples one time unit after each expectation is queued, away from clock edges.
    initial begin
        exp_t e;
        forever begin
            @(push_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (o !== e.o) begin
                    n_bad++;
                    $display("FAIL %s.o got %h want %h", e.name, o, e.o);
                end
                n_cmp++;
                if (sel_any !== e.sel_any) begin
                    n_bad++;
                    $display("FAIL %s.sel_any got %b want %b", e.name, sel_any, e.sel_any);
                end
                n_cmp++;
                if (o_q !== e.o_q) begin
                    n_bad++;
                    $display("FAIL %s.o_q got %h want %h", e.name, o_q, e.o_q);
                end
                n_cmp++;
                if (collision !== e.collision) begin
                    n_bad++;
                    $display("FAIL %s.collision got %b want %b", e.name, collision, e.collision);
                end
                done_cnt++;
            end
        end
    end

    task automatic expect_now(input string name, input logic [7:0] eo, input logic es,
                              input logic [7:0] eq, input logic ec);
        exp_t e;
        int   target;
        e.name = name; e.o = eo; e.sel_any = es; e.o_q = eq; e.collision = ec;
        target = done_cnt + 1;
        exp_q.push_back(e);
        -> push_ev;
        for (int k = 0; k < 20 && done_cnt < target; k++) #1;
        if (done_cnt < target) begin
            n_bad++;
            $display("FAIL %s.timeout got %0d want %0d", name, done_cnt, target);
            exp_q.delete();
        end
    endtask

    task automatic sel(input logic sa, input logic sb, input logic sc, input logic sd);
        a_addr = sa; b_addr = sb; c_addr = sc; d_addr = sd;
    endtask

    // Advance through exactly one rising edge, landing on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; clr_err = 1'b0;
        a = 8'hAA; b = 8'hBB; c = 8'hCC; d = 8'hDD;
        sel(0, 0, 0, 0);
        #1;
        expect_now("reset", 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        tick();
        expect_now("idle", 8'h00, 1'b0, 8'h00, 1'b0);

        sel(1, 0, 0, 0);
        expect_now("a_comb", 8'hAA, 1'b1, 8'h00, 1'b0);
        tick();
        expect_now("a_reg", 8'hAA, 1'b1, 8'hAA, 1'b0);

        sel(0, 1, 0, 0);
        expect_now("b_comb", 8'hBB, 1'b1, 8'hAA, 1'b0);
        tick();
        expect_now("b_reg", 8'hBB, 1'b1, 8'hBB, 1'b0);

        sel(0, 0, 1, 0);
        expect_now("c_comb", 8'hCC, 1'b1, 8'hBB, 1'b0);
        tick();
        expect_now("c_reg", 8'hCC, 1'b1, 8'hCC, 1'b0);

        sel(0, 0, 0, 1);
        expect_now("d_comb", 8'hDD, 1'b1, 8'hCC, 1'b0);
        tick();
        expect_now("d_reg", 8'hDD, 1'b1, 8'hDD, 1'b0);

        sel(0, 0, 0, 0);
        expect_now("none_comb", 8'h00, 1'b0, 8'hDD, 1'b0);
        tick();
        expect_now("none_reg", 8'h00, 1'b0, 8'h00, 1'b0);

        sel(1, 0, 1, 0);
        expect_now("ac_comb", 8'hAA, 1'b1, 8'h00, 1'b0);
        tick();
        expect_now("ac_coll", 8'hAA, 1'b1, 8'hAA, 1'b1);

        sel(0, 0, 0, 0);
        tick();
        expect_now("coll_sticky", 8'h00, 1'b0, 8'h00, 1'b1);

        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        expect_now("coll_clear", 8'h00, 1'b0, 8'h00, 1'b0);

        sel(0, 1, 1, 1);
        expect_now("bcd_comb", 8'hBB, 1'b1, 8'h00, 1'b0);
        sel(0, 1, 0, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        expect_now("set_wins", 8'hBB, 1'b1, 8'hBB, 1'b1);

        sel(0, 0, 0, 1);
        tick();
        expect_now("pre_rst", 8'hDD, 1'b1, 8'hDD, 1'b1);

        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_rst", 8'hDD, 1'b1, 8'h00, 1'b0);

        a = 8'hxx;
        sel(0, 1, 0, 0);
        expect_now("x_blocked", 8'hBB, 1'b1, 8'h00, 1'b0);
        tick();
        expect_now("held_rst", 8'hBB, 1'b1, 8'h00, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_now("resume", 8'hBB, 1'b1, 8'hBB, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sel_mux_8bit.md
Name: sel_mux_8bit

Overview:
- One-hot-select data multiplexer for the TIPI PEB CPLD read-back path.
- Four 8-bit sources, each with its own address-decode select line, drive one shared 8-bit output.
- Output is zero when no source is selected, so the result can be OR-ed onto a wider bus.
- Adds a registered copy of the output and a sticky collision flag for multiple simultaneous selects.

Parameters:
- WIDTH, 8, data width of each source and of the output.

Ports:
- clk  input  1  system clock; only the registered outputs use it.
- rst_n  input  1  asynchronous active-low reset.
- a_addr  input  1  select for source a, active high.
- a  input  WIDTH  source a data.
- b_addr  input  1  select for source b, active high.
- b  input  WIDTH  source b data.
- c_addr  input  1  select for source c, active high.
- c  input  WIDTH  source c data.
- d_addr  input  1  select for source d, active high.
- d  input  WIDTH  source d data.
- clr_err  input  1  synchronous clear of the collision flag.
- o  output  WIDTH  combinational mux result.
- o_q  output  WIDTH  o registered on the rising edge of clk.
- sel_any  output  1  combinational OR of the four selects.
- collision  output  1  sticky flag: two or more selects were high on a clock edge.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- o is purely combinational, with zero latency. It is valid within one simulation delta of any select or data change and needs no clock edge.
- Mux rules for o:
  - No select high: o = 0.
  - Exactly one select high: o = that source's data.
  - Multiple selects high: fixed priority a > b > c > d; o = data of the highest-priority asserted source.
- sel_any = a_addr | b_addr | c_addr | d_addr, combinational.
- o_q: on the rising edge of clk, o_q <= o. One cycle of latency. While rst_n is low, o_q = 0 asynchronously.
- collision:
  - On the rising edge of clk, set to 1 if two or more selects are high. It then stays 1 until cleared.
  - clr_err high on a clock edge clears it to 0. If clr_err and a new collision occur on the same edge, set wins and collision = 1.
  - While rst_n is low, collision = 0 asynchronously.
- Reset values: o_q = 0, collision = 0. o and sel_any are unaffected by reset and keep following their inputs.
- Reset deasserted mid-operation: registers resume capturing on the first clock edge after release; there is no extra pipeline bubble.
- X on an unselected source must not propagate to o.
- No internal state beyond o_q and collision.

Test Plan:
- All selects 0; a=AA, b=BB, c=CC, d=DD -> o=00, sel_any=0; after one clk, o_q=00.
- a_addr=1 only -> o=AA immediately (no clock); after one clk edge, o_q=AA; collision=0.
- Select b, then c, then d in turn, deasserting the previous select first -> o=BB, CC, DD respectively; all selects back to 0 -> o=00.
- a_addr=1 and c_addr=1 together, then clk edge -> o=AA (priority), collision=1. Deassert both selects -> collision stays 1. clr_err=1 for one edge -> collision=0.
- clr_err=1 with b_addr=d_addr=1 on the same edge -> collision=1 and o=BB.
- With o_q=DD and collision=1, drive rst_n=0 with no clock -> o_q=00 and collision=0 immediately; o still equals DD while d_addr=1.
